// File: rtl/tpg_div_pkg.sv
// Shared constants and types for the TPG signed/unsigned sequential divider.
package tpg_div_pkg;

  localparam int unsigned DIVIDEND_W = 24;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned QUOT_W     = 16;
  localparam int unsigned STEPS      = 24;
  localparam int unsigned CNT_W      = $clog2(STEPS);

  localparam logic [QUOT_W-1:0] QUOT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tpg_div_step.sv
// One combinational radix-2 restoring division step.
//   i_rem  : partial remainder before the step (always < |divisor|)
//   i_bit  : next dividend bit, MSB first
//   i_dsr  : |divisor| (128 representable)
//   o_rem  : partial remainder after the step
//   o_qbit : quotient bit produced by this step
module tpg_div_step
  import tpg_div_pkg::*;
#(
  parameter int unsigned DW = DIVISOR_W
) (
  input  logic [DW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_dsr,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);

  logic [DW:0]   w_shift;
  logic [DW+1:0] w_diff;

  // Shifted remainder needs DW+1 bits; the extra MSB of the difference is the borrow.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = {1'b0, w_shift} - {2'b00, i_dsr};
    o_qbit  = ~w_diff[DW+1];
    o_rem   = DW'(o_qbit ? w_diff : {1'b0, w_shift});
  end

endmodule

// File: rtl/tpg_div_24s_8s_16u.sv
// Iterative divider: signed dividend / signed divisor -> saturating unsigned
// quotient plus remainder carrying the dividend's sign. One restoring step per
// ce cycle, valid/ready on both sides.
//   clk, reset_n           : clock, async active-low reset
//   ce                     : clock enable, everything holds when low
//   in_valid / in_ready    : operand handshake (ready only in IDLE)
//   dividend, divisor      : signed operands
//   out_valid / out_ready  : result handshake
//   quotient, remainder    : result, held until the next fix-up
//   ovf, dz                : quotient clamped / divisor was zero
module tpg_div_24s_8s_16u #(
  parameter int unsigned DIVIDEND_W = tpg_div_pkg::DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = tpg_div_pkg::DIVISOR_W,
  parameter int unsigned QUOT_W     = tpg_div_pkg::QUOT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dz
);

  import tpg_div_pkg::*;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [DIVIDEND_W-1:0]   r_dq;
  logic [DIVISOR_W-1:0]    r_rem;
  logic [DIVISOR_W-1:0]    r_dsr;
  logic                    r_qneg;
  logic                    r_dneg;
  logic                    r_dz;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [QUOT_W-1:0]       r_quot;
  logic [DIVISOR_W-1:0]    r_rem_out;
  logic                    r_ovf;
  logic                    r_dz_out;

  logic                    w_load;
  logic                    w_step;
  logic                    w_fix;
  logic                    w_in_ready_nxt;
  logic                    w_out_valid_nxt;
  logic [DIVIDEND_W:0]     w_dvd_ext;
  logic [DIVIDEND_W:0]     w_dvd_abs;
  logic [DIVISOR_W-1:0]    w_dsr_abs;
  logic [DIVISOR_W-1:0]    w_step_rem;
  logic                    w_step_q;
  logic                    w_big;
  logic [QUOT_W-1:0]       w_quot_f;
  logic [DIVISOR_W-1:0]    w_rem_f;
  logic                    w_ovf_f;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_nxt = CALC;
      CALC: if (r_cnt == CNT_W'(STEPS - 1)) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_load          = 1'b0;
    w_step          = 1'b0;
    w_fix           = 1'b0;
    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_out_valid_nxt = (w_state_nxt == DONE);
    unique case (r_state)
      IDLE:    w_load = in_valid;
      CALC:    w_step = 1'b1;
      FIX:     w_fix  = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes; one extra dividend bit keeps -2^(N-1) exact, -128 maps to 128.
  always_comb begin
    w_dvd_ext = {dividend[DIVIDEND_W-1], dividend};
    w_dvd_abs = dividend[DIVIDEND_W-1] ? (~w_dvd_ext + (DIVIDEND_W+1)'(1)) : w_dvd_ext;
    w_dsr_abs = divisor[DIVISOR_W-1] ? (~divisor + DIVISOR_W'(1)) : divisor;
  end

  tpg_div_step #(.DW(DIVISOR_W)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dq[DIVIDEND_W-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_q)
  );

  // Sign fix-up and saturation; a zero-magnitude quotient is never negative.
  always_comb begin
    w_big    = |r_dq[DIVIDEND_W-1:QUOT_W];
    w_quot_f = r_dq[QUOT_W-1:0];
    w_rem_f  = r_dneg ? (~r_rem + DIVISOR_W'(1)) : r_rem;
    w_ovf_f  = 1'b0;
    if (r_dz) begin
      w_quot_f = QUOT_W'(QUOT_MAX);
      w_rem_f  = '0;
      w_ovf_f  = 1'b1;
    end else if (r_qneg && (|r_dq)) begin
      w_quot_f = '0;
      w_ovf_f  = 1'b1;
    end else if (w_big) begin
      w_quot_f = QUOT_W'(QUOT_MAX);
      w_ovf_f  = 1'b1;
    end
  end

  // Datapath: dividend shifts out MSB first while quotient bits shift in at the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_dq        <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_qneg      <= 1'b0;
      r_dneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem_out   <= '0;
      r_ovf       <= 1'b0;
      r_dz_out    <= 1'b0;
    end else if (ce) begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load) begin
        r_cnt  <= '0;
        r_rem  <= '0;
        r_dq   <= DIVIDEND_W'(w_dvd_abs);
        r_dsr  <= w_dsr_abs;
        r_qneg <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
        r_dneg <= dividend[DIVIDEND_W-1];
        r_dz   <= (divisor == '0);
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_rem <= w_step_rem;
        r_dq  <= {r_dq[DIVIDEND_W-2:0], w_step_q};
      end
      if (w_fix) begin
        r_quot    <= w_quot_f;
        r_rem_out <= w_rem_f;
        r_ovf     <= w_ovf_f;
        r_dz_out  <= r_dz;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem_out;
  assign ovf       = r_ovf;
  assign dz        = r_dz_out;

endmodule

// File: tb/tb_tpg_div_24s_8s_16u.sv
`timescale 1ns/1ps
// Scoreboard bench for the sequential divider: the driver pushes the
// arithmetic-model result at each acceptance, the monitor pops and compares
// at each output handshake and also tracks latency and output stability.
module tb_tpg_div_24s_8s_16u;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dz;

  int   checks = 0;
  int   failures = 0;
  int   ce_mode = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];

  tpg_div_24s_8s_16u dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // C-style truncating division, then clamp into the unsigned quotient range.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    int   r;
    e = '0;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = 8'd0; e.ovf = 1'b1; e.dz = 1'b1;
      return e;
    end
    q = a / b;
    r = a % b;
    e.r = 8'(r);
    if (q < 0) begin
      e.q = 16'd0; e.ovf = 1'b1;
    end else if (q > 65535) begin
      e.q = 16'hFFFF; e.ovf = 1'b1;
    end else begin
      e.q = 16'(q);
    end
    return e;
  endfunction

  // Clock-enable pattern: steady, alternating, or random.
  initial forever begin
    @(posedge clk); #1;
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = ~ce;
      default: ce = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Downstream readiness: always, random, or stalled.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 1) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input int a, input int b);
    int w;
    @(posedge clk); #1;
    dividend = 24'(a);
    divisor  = 8'(b);
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (reset_n && in_valid && in_ready && ce) break;
      w++;
      if (w > 3000) break;
    end
    if (w > 3000) begin
      check("accept_timeout", 1'b0, $sformatf("operands %0d/%0d never accepted", a, b));
    end else begin
      exp_q.push_back(model(a, b));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 24'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0)
      check("drain_timeout", 1'b0, $sformatf("%0d results still pending", exp_q.size()));
    @(negedge clk);
  endtask

  // Monitor: latency in ce-high edges, output stability, and result scoreboard.
  initial begin
    exp_t snap;
    exp_t got;
    exp_t e;
    logic prev_valid;
    logic last_ce;
    bit   lat_run;
    int   lat_cnt;
    snap = '0; prev_valid = 1'b0; last_ce = 1'b0; lat_run = 0; lat_cnt = 0;
    forever begin
      @(negedge clk);
      got = '{q: quotient, r: remainder, ovf: ovf, dz: dz};
      if (!reset_n) begin
        exp_q.delete();
        lat_run    = 0;
        prev_valid = 1'b0;
        last_ce    = 1'b0;
        snap       = '0;
      end else begin
        if (lat_run && last_ce) lat_cnt++;
        if (lat_run && out_valid) begin
          check("latency", lat_cnt == 25,
                $sformatf("out_valid after %0d ce edges, required 25", lat_cnt));
          lat_run = 0;
        end else if (lat_run && lat_cnt > 25) begin
          check("latency_timeout", 1'b0, $sformatf("no out_valid after %0d ce edges", lat_cnt));
          lat_run = 0;
        end
        if (!(out_valid && !prev_valid)) begin
          check("hold", (got == snap) && !(out_valid && in_ready),
                $sformatf("outputs %h in_ready %b, required %h held with in_ready 0",
                          got, in_ready, snap));
        end
        if (out_valid && out_ready && ce) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1'b0, $sformatf("got %h with empty scoreboard", got));
          end else begin
            e = exp_q.pop_front();
            check("result", got == e,
                  $sformatf("q=%0d r=%0d ovf=%b dz=%b, required q=%0d r=%0d ovf=%b dz=%b",
                            got.q, $signed(got.r), got.ovf, got.dz,
                            e.q, $signed(e.r), e.ovf, e.dz));
          end
        end
        if (in_valid && in_ready && ce) begin
          lat_run = 1;
          lat_cnt = -1;
        end
        snap       = got;
        prev_valid = out_valid;
        last_ce    = ce;
      end
    end
  end

  initial begin
    logic signed [23:0] sd;
    logic signed [7:0]  sb;
    int a;
    int b;
    int w;

    repeat (3) @(posedge clk);
    #2;
    check("reset_state", in_ready && !out_valid && quotient == 16'd0 && remainder == 8'd0
          && !ovf && !dz,
          $sformatf("in_ready=%b out_valid=%b q=%h r=%h ovf=%b dz=%b, required 1 0 0 0 0 0",
                    in_ready, out_valid, quotient, remainder, ovf, dz));
    reset_n = 1'b1;

    send(-3000, -3);        drain();
    send(8322945, 127);     drain();
    send(8322946, 127);     drain();
    send(-7, 2);            drain();
    send(8388607, 1);       drain();
    send(-8388608, -128);   drain();
    send(1234, 0);          drain();
    send(5, -7);            drain();
    send(0, -5);            drain();
    send(-129, 128 - 256);  drain();

    // Back-pressure: result must sit untouched while downstream stalls.
    rdy_mode = 2;
    send(-3000, 7);
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    check("backpressure", out_valid && !in_ready,
          $sformatf("out_valid=%b in_ready=%b after stall, required 1 0", out_valid, in_ready));
    rdy_mode = 0;
    drain();

    // Alternating clock enable.
    ce_mode = 1;
    send(8322946, 127);     drain();
    send(-1000, 9);         drain();
    ce_mode = 0;
    @(posedge clk); #1;

    // Reset in the middle of CALC.
    send(8388607, 1);       drain();
    send(5000, 3);
    repeat (12) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset", in_ready && !out_valid && quotient == 16'd0 && remainder == 8'd0
          && !ovf && !dz,
          $sformatf("in_ready=%b out_valid=%b q=%h r=%h ovf=%b dz=%b, required 1 0 0 0 0 0",
                    in_ready, out_valid, quotient, remainder, ovf, dz));
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    send(100, 7);           drain();

    // Randomised traffic with random stalls on both sides.
    ce_mode  = 2;
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      sd = 24'($urandom);
      sd = sd >>> $urandom_range(0, 20);
      sb = 8'($urandom);
      a  = int'(sd);
      b  = ($urandom_range(0, 9) == 0) ? 0 : int'(sb);
      send(a, b);
    end
    drain();
    ce_mode  = 0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
